des_key_schedule: RTL and testbench
===================================

DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 1, legal values 1 or 3: count of 64-bit keys; 3 selects triple-DES EDE scheduling.
REQ-002 SHALL have port i_clk, input, 1: sole clock; all logic on the rising edge.
REQ-003 SHALL have port i_rst_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port i_key, input, 64*NUM_KEYS: key bundle; key n occupies bits [64n+63:64n], key 0 = K1.
REQ-005 SHALL have port i_decrypt, input, 1: 1 = decryption subkey order; sampled with i_key.
REQ-006 SHALL have port i_key_valid, input, 1: key bundle offered.
REQ-007 SHALL have port o_key_ready, output, 1: block accepts a key bundle this cycle.
REQ-008 SHALL have port o_subkey, output, 48: current round subkey.
REQ-009 SHALL have port o_subkey_valid, output, 1: o_subkey, o_round, o_key_idx and o_last valid.
REQ-010 SHALL have port i_subkey_ready, input, 1: consumer takes the subkey.
REQ-011 SHALL have port o_round, output, 4: DES round index 0..15 (round 1..16) of o_subkey.
REQ-012 SHALL have port o_key_idx, output, 2: index of the key producing o_subkey.
REQ-013 SHALL have port o_last, output, 1: final subkey of the bundle.

Function
REQ-014 SHALL use FSM states IDLE and GEN; o_key_ready = 1 only in IDLE; o_subkey_valid = 1 only in GEN.
REQ-015 SHALL accept a bundle on a rising edge where i_key_valid & o_key_ready: latch i_key, i_decrypt, and 56-bit C/D = PC-1(active key); enter GEN.
REQ-016 SHALL present the first subkey in the cycle after acceptance (latency 1).
REQ-017 SHALL drive o_subkey combinationally as PC-2 of the C/D register, stable while o_subkey_valid & !i_subkey_ready.
REQ-018 SHALL, in forward passes, load C/D left-rotated by shift(1) at pass start and, on each handshake, rotate left by shift(r+1); shift table = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-019 SHALL, in reverse passes, load unrotated PC-1 (yields K16) and, on each handshake, rotate right by shift(r), r = current round; o_round counts 15 down to 0.
REQ-020 SHALL, for NUM_KEYS=3, run three passes: encrypt = key0 fwd, key1 rev, key2 fwd; decrypt = key2 rev, key1 fwd, key0 rev; next pass loads on the handshake of the prior pass's round-16/round-1 subkey, with no gap cycle.
REQ-021 SHALL assert o_last on subkey 16*NUM_KEYS; its handshake returns the FSM to IDLE.
REQ-022 SHALL ignore i_key_valid while in GEN; a new bundle is accepted no earlier than the cycle after o_last's handshake.
REQ-023 SHALL hold all state when o_subkey_valid & !i_subkey_ready.

Reset
REQ-024 SHALL, on i_rst_n=0 at a clock edge, go to IDLE from any state, abandoning any schedule in progress: o_key_ready=1, o_subkey_valid=0, o_round=0, o_key_idx=0, o_last=0, C/D=0, o_subkey=PC-2(0)=0.

Configuration
REQ-025 SHALL, with DES_KEY_PARITY_CHECK_EN defined, add output o_parity_err (1 bit), set at acceptance if any byte of any latched key has even parity, held until the next acceptance, reset 0; generation proceeds regardless.
REQ-026 SHALL, without DES_KEY_PARITY_CHECK_EN, omit o_parity_err and all parity logic; parity bits are ignored.

Structure
REQ-027 SHALL place the shift table, PC-1/PC-2 tables, the 56-bit C/D and 48-bit subkey typedefs, and the state enum in package des_key_pkg.
REQ-028 SHALL use one combinational sub-module des_key_permute (PC-1 and PC-2); the FSM, rotation and handshake live in des_key_schedule.

Verification
REQ-029 SHALL verify: NUM_KEYS=1, key 133457799BBCDFF1, i_decrypt=0, ready tied 1 -> first subkey 1B02EFFC7072 (round 0), second 79AED9DBC9E5, 16th CB3D8B0E17F5 with o_last.
REQ-030 SHALL verify: same key, i_decrypt=1 -> first subkey CB3D8B0E17F5 (o_round=15), 16th 1B02EFFC7072 (o_round=0, o_last).
REQ-031 SHALL verify: NUM_KEYS=3, all keys 133457799BBCDFF1, encrypt -> 48 subkeys: K1..K16, K16..K1, K1..K16; o_key_idx 0,1,2; no gap between passes.
REQ-032 SHALL verify: i_subkey_ready held low 5 cycles at round 3 -> o_subkey/o_round frozen, no skipped or duplicated subkey.
REQ-033 SHALL verify: i_rst_n=0 for 1 cycle mid-schedule (round 7) -> next cycle o_subkey_valid=0, o_key_ready=1; a new bundle restarts at round 0.
REQ-034 SHALL verify: with DES_KEY_PARITY_CHECK_EN, key 0000000000000000 -> o_parity_err=1; key 133457799BBCDFF1 -> 0.

Source files
------------

// File: rtl/des_key_pkg.sv
// des_key_pkg: shared types, tables and rotation helpers for the DES key
// schedule.
//   cd_t      : 56-bit C/D register (C = [55:28], D = [27:0])
//   subkey_t  : 48-bit round subkey
//   state_t   : scheduler FSM states
// PC-1/PC-2 entries are the standard 1-based, MSB-first DES bit positions.
package des_key_pkg;

  typedef logic [55:0] cd_t;
  typedef logic [47:0] subkey_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GEN  = 1'b1
  } state_t;

  localparam logic [1:0] SHIFT_TABLE [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  localparam logic [5:0] PC1_TABLE [56] = '{
    6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
    6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
    6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
    6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
    6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
    6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
    6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
    6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
  };

  localparam logic [5:0] PC2_TABLE [48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  // C and D rotate independently as 28-bit halves.
  function automatic cd_t cd_rotl(cd_t cd, logic two);
    logic [27:0] c;
    logic [27:0] d;
    c = cd[55:28];
    d = cd[27:0];
    if (two) return {c[25:0], c[27:26], d[25:0], d[27:26]};
    return {c[26:0], c[27], d[26:0], d[27]};
  endfunction

  function automatic cd_t cd_rotr(cd_t cd, logic two);
    logic [27:0] c;
    logic [27:0] d;
    c = cd[55:28];
    d = cd[27:0];
    if (two) return {c[1:0], c[27:2], d[1:0], d[27:2]};
    return {c[0], c[27:1], d[0], d[27:1]};
  endfunction

endpackage

// File: rtl/des_key_permute.sv
// des_key_permute: purely combinational PC-1 and PC-2 permutations.
//   key     : 64-bit DES key (parity bits are dropped by PC-1)
//   cd      : 56-bit C/D register contents
//   key_pc1 : PC-1(key)
//   subkey  : PC-2(cd)
module des_key_permute
  import des_key_pkg::*;
(
  input  logic [63:0] key,
  input  cd_t         cd,
  output cd_t         key_pc1,
  output subkey_t     subkey
);

  always_comb begin
    key_pc1 = '0;
    for (int i = 0; i < 56; i++) begin
      key_pc1[55-i] = key[6'd63 - (PC1_TABLE[i] - 6'd1)];
    end
  end

  always_comb begin
    subkey = '0;
    for (int i = 0; i < 48; i++) begin
      subkey[47-i] = cd[6'd55 - (PC2_TABLE[i] - 6'd1)];
    end
  end

  // Parity bits of key and the eight C/D bits PC-2 discards are intentionally unused.
  logic unused_bits;
  assign unused_bits = ^key ^ ^cd;

endmodule

// File: rtl/des_key_schedule.sv
// des_key_schedule: DES / triple-DES (EDE) round subkey generator with a
// valid/ready key input and a valid/ready subkey output.
//   i_clk, i_rst_n             : clock, synchronous active-low reset
//   i_key[64*NUM_KEYS-1:0]     : key bundle, key n at [64n+63:64n]
//   i_decrypt, i_key_valid     : bundle direction / offer
//   o_key_ready                : bundle accepted this cycle if offered
//   o_subkey, o_subkey_valid   : current subkey and its valid
//   i_subkey_ready             : consumer takes the subkey
//   o_round, o_key_idx, o_last : round 0..15, source key, final subkey
//   o_parity_err               : only with DES_KEY_PARITY_CHECK_EN defined;
//                                some byte of the latched bundle has even parity
//
// state   | meaning
// IDLE    | waiting for a key bundle, o_key_ready = 1
// GEN     | presenting subkeys, advancing one per handshake
module des_key_schedule
  import des_key_pkg::*;
#(
  parameter int NUM_KEYS = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [64*NUM_KEYS-1:0]  i_key,
  input  logic                    i_decrypt,
  input  logic                    i_key_valid,
  output logic                    o_key_ready,
  output logic [47:0]             o_subkey,
  output logic                    o_subkey_valid,
  input  logic                    i_subkey_ready,
  output logic [3:0]              o_round,
  output logic [1:0]              o_key_idx,
  output logic                    o_last
`ifdef DES_KEY_PARITY_CHECK_EN
  ,
  output logic                    o_parity_err
`endif
);

  localparam logic [1:0] LAST_PASS = 2'(NUM_KEYS - 1);

  state_t                 state_q, state_d;
  logic [64*NUM_KEYS-1:0] key_q;
  logic                   decrypt_q;
  cd_t                    cd_q;
  logic [3:0]             round_q;
  logic [1:0]             pass_q;

  logic       accept, hs, rev_cur, pass_end, last_sub, load, step;
  logic       load_dec, load_rev;
  logic [1:0] load_pass;
  logic [63:0] src_key;
  logic [64*NUM_KEYS-1:0] src_bundle;
  cd_t        pc1_cd;

  // EDE order: encrypt walks keys 0,1,2; decrypt walks 2,1,0.
  function automatic logic [1:0] key_idx_f(logic [1:0] pass, logic dec);
    return (NUM_KEYS == 1) ? 2'd0 : (dec ? 2'd2 - pass : pass);
  endfunction

  always_comb begin
    accept    = (state_q == ST_IDLE) && i_key_valid;
    hs        = (state_q == ST_GEN) && i_subkey_ready;
    // Middle pass runs opposite to the bundle direction.
    rev_cur   = decrypt_q ^ (pass_q == 2'd1);
    pass_end  = rev_cur ? (round_q == 4'd0) : (round_q == 4'd15);
    last_sub  = (state_q == ST_GEN) && pass_end && (pass_q == LAST_PASS);
    load_dec  = accept ? i_decrypt : decrypt_q;
    load_pass = accept ? 2'd0 : pass_q + 2'd1;
    load_rev  = load_dec ^ (load_pass == 2'd1);
    load      = accept || (hs && pass_end && !last_sub);
    step      = hs && !pass_end;
  end

  // Source key for a pass load: the incoming bundle at acceptance,
  // the latched bundle at a pass boundary.
  assign src_bundle = accept ? i_key : key_q;

  if (NUM_KEYS == 1) begin : g_single
    assign src_key = src_bundle;
  end else begin : g_triple
    logic [1:0] load_idx;
    assign load_idx = key_idx_f(load_pass, load_dec);
    always_comb begin
      case (load_idx)
        2'd0:    src_key = src_bundle[63:0];
        2'd1:    src_key = src_bundle[127:64];
        default: src_key = src_bundle[64*NUM_KEYS-1 -: 64];
      endcase
    end
  end

  des_key_permute u_permute (
    .key     (src_key),
    .cd      (cd_q),
    .key_pc1 (pc1_cd),
    .subkey  (o_subkey)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_key_valid)     state_d = ST_GEN;
      ST_GEN:  if (hs && last_sub)  state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_key_ready    = (state_q == ST_IDLE);
    o_subkey_valid = (state_q == ST_GEN);
    o_last         = last_sub;
    o_round        = round_q;
    o_key_idx      = key_idx_f(pass_q, decrypt_q);
  end

  // Forward passes start at C1/D1, reverse passes at C16/D16 (= C0/D0).
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      key_q     <= '0;
      decrypt_q <= 1'b0;
      cd_q      <= '0;
      round_q   <= 4'd0;
      pass_q    <= 2'd0;
    end else begin
      if (accept) begin
        key_q     <= i_key;
        decrypt_q <= i_decrypt;
      end
      if (load) begin
        cd_q    <= load_rev ? pc1_cd : cd_rotl(pc1_cd, SHIFT_TABLE[0] == 2'd2);
        round_q <= load_rev ? 4'd15 : 4'd0;
        pass_q  <= load_pass;
      end else if (step) begin
        if (rev_cur) begin
          cd_q    <= cd_rotr(cd_q, SHIFT_TABLE[round_q] == 2'd2);
          round_q <= round_q - 4'd1;
        end else begin
          cd_q    <= cd_rotl(cd_q, SHIFT_TABLE[round_q + 4'd1] == 2'd2);
          round_q <= round_q + 4'd1;
        end
      end
    end
  end

`ifdef DES_KEY_PARITY_CHECK_EN
  function automatic logic any_even_byte(logic [64*NUM_KEYS-1:0] k);
    logic found;
    found = 1'b0;
    for (int b = 0; b < 8*NUM_KEYS; b++) found = found | ~^k[8*b +: 8];
    return found;
  endfunction

  logic parity_err_q;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)    parity_err_q <= 1'b0;
    else if (accept) parity_err_q <= any_even_byte(i_key);
  end
  assign o_parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
`timescale 1ns/1ps
module tb_des_key_schedule;

  typedef struct {
    logic [47:0] sk;
    logic [3:0]  rnd;
    logic [1:0]  idx;
    logic        last;
  } exp_t;

  typedef struct {
    int           sel;
    logic [191:0] keys;
    logic         dec;
    logic [47:0]  sk;
    logic [3:0]   rnd;
    logic [1:0]   idx;
  } vec_t;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_Z = 64'h0;
  localparam logic [63:0] KEY_F = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [47:0] SK_F  = 48'hFFFF_FFFF_FFFF;

  logic [47:0] ks_a [16];

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [63:0]  key1 = '0;
  logic         dec1 = 1'b0, kv1 = 1'b0, rdy1 = 1'b0;
  logic         kr1, v1, last1;
  logic [47:0]  sk1;
  logic [3:0]   rnd1;
  logic [1:0]   idx1;

  logic [191:0] key3 = '0;
  logic         dec3 = 1'b0, kv3 = 1'b0, rdy3 = 1'b0;
  logic         kr3, v3, last3;
  logic [47:0]  sk3;
  logic [3:0]   rnd3;
  logic [1:0]   idx3;

`ifdef DES_KEY_PARITY_CHECK_EN
  logic perr1, perr3;
`endif

  int n_pass = 0;
  int n_total = 0;
  exp_t q1[$];
  exp_t q3[$];

  always #5 clk = ~clk;

  des_key_schedule #(.NUM_KEYS(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_key(key1), .i_decrypt(dec1),
    .i_key_valid(kv1), .o_key_ready(kr1), .o_subkey(sk1),
    .o_subkey_valid(v1), .i_subkey_ready(rdy1), .o_round(rnd1),
    .o_key_idx(idx1), .o_last(last1)
`ifdef DES_KEY_PARITY_CHECK_EN
    , .o_parity_err(perr1)
`endif
  );

  des_key_schedule #(.NUM_KEYS(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_key(key3), .i_decrypt(dec3),
    .i_key_valid(kv3), .o_key_ready(kr3), .o_subkey(sk3),
    .o_subkey_valid(v3), .i_subkey_ready(rdy3), .o_round(rnd3),
    .o_key_idx(idx3), .o_last(last3)
`ifdef DES_KEY_PARITY_CHECK_EN
    , .o_parity_err(perr3)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_total++;
    $display("FAIL %s", name);
  endtask

  // {key_ready, valid, last, idx, round, subkey}
  function automatic logic [63:0] outs(input int sel);
    if (sel == 1) return {7'd0, kr1, v1, last1, idx1, rnd1, sk1};
    return {7'd0, kr3, v3, last3, idx3, rnd3, sk3};
  endfunction

  function automatic logic [47:0] exp_subkey(input logic [63:0] k, input int rnd);
    if (k == KEY_A) return ks_a[rnd];
    if (k == KEY_F) return SK_F;
    return 48'd0;
  endfunction

  function automatic int qsize(input int sel);
    return (sel == 1) ? q1.size() : q3.size();
  endfunction

  // Expected stream for a bundle, derived from the EDE pass order.
  task automatic push_bundle(input int sel, input logic [191:0] keys, input logic dec);
    int nk;
    exp_t e;
    nk = (sel == 1) ? 1 : 3;
    for (int p = 0; p < nk; p++) begin
      int kidx;
      logic rev;
      logic [63:0] k;
      kidx = (nk == 1) ? 0 : (dec ? 2 - p : p);
      rev  = dec ^ (p == 1);
      k    = keys[64*kidx +: 64];
      for (int j = 0; j < 16; j++) begin
        int rnd;
        rnd    = rev ? 15 - j : j;
        e.sk   = exp_subkey(k, rnd);
        e.rnd  = 4'(rnd);
        e.idx  = 2'(kidx);
        e.last = (p == nk - 1) && (j == 15);
        if (sel == 1) q1.push_back(e);
        else          q3.push_back(e);
      end
    end
  endtask

  task automatic send(input int sel, input logic [191:0] keys, input logic dec);
    logic [63:0] o;
    @(posedge clk); #1;
    o = outs(sel);
    chk("ready before send", {63'd0, o[56]}, 64'd1);
    if (sel == 1) begin key1 = keys[63:0]; dec1 = dec; kv1 = 1'b1; end
    else          begin key3 = keys;       dec3 = dec; kv3 = 1'b1; end
    push_bundle(sel, keys, dec);
    @(posedge clk); #1;
    kv1 = 1'b0;
    kv3 = 1'b0;
  endtask

  task automatic wait_drain(input int sel, input int target, input int exp_cyc);
    int cyc;
    cyc = 0;
    while (qsize(sel) > target && cyc < 2000) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    if (qsize(sel) > target) fail("drain timeout");
    else if (exp_cyc > 0) chk("handshake cycles", 64'(cyc), 64'(exp_cyc));
  endtask

  task automatic chk_idle(input int sel);
    logic [63:0] o;
    o = outs(sel);
    chk("idle ready/valid", {62'd0, o[56:55]}, 64'd2);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (v1 && rdy1) begin
        if (q1.size() == 0) fail("dut1 spurious subkey");
        else begin
          e = q1.pop_front();
          chk("dut1 stream", {9'd0, idx1, rnd1, last1, sk1}, {9'd0, e.idx, e.rnd, e.last, e.sk});
        end
      end
      if (v3 && rdy3) begin
        if (q3.size() == 0) fail("dut3 spurious subkey");
        else begin
          e = q3.pop_front();
          chk("dut3 stream", {9'd0, idx3, rnd3, last3, sk3}, {9'd0, e.idx, e.rnd, e.last, e.sk});
        end
      end
      if (v1 || v3) chk("ready/valid exclusive", {62'd0, kr1 & v1, kr3 & v3}, 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    logic [63:0] o;
    int cnt;

    ks_a = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
             48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
             48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
             48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

    vecs[0] = '{1, {128'd0, KEY_A},        1'b0, 48'h1B02EFFC7072, 4'd0,  2'd0};
    vecs[1] = '{1, {128'd0, KEY_A},        1'b1, 48'hCB3D8B0E17F5, 4'd15, 2'd0};
    vecs[2] = '{3, {KEY_A, KEY_A, KEY_A},  1'b0, 48'h1B02EFFC7072, 4'd0,  2'd0};
    vecs[3] = '{3, {KEY_A, KEY_A, KEY_A},  1'b1, 48'hCB3D8B0E17F5, 4'd15, 2'd2};
    vecs[4] = '{3, {KEY_F, KEY_Z, KEY_A},  1'b0, 48'h1B02EFFC7072, 4'd0,  2'd0};
    vecs[5] = '{3, {KEY_F, KEY_Z, KEY_A},  1'b1, SK_F,             4'd15, 2'd2};
    vecs[6] = '{1, {128'd0, KEY_F},        1'b0, SK_F,             4'd0,  2'd0};

    repeat (2) @(posedge clk);
    #1;
    chk("dut1 reset outputs", outs(1), {7'd0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 48'd0});
    chk("dut3 reset outputs", outs(3), {7'd0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 48'd0});
`ifdef DES_KEY_PARITY_CHECK_EN
    chk("parity reset", {63'd0, perr1}, 64'd0);
`endif
    rst_n = 1'b1;
    rdy1 = 1'b1;
    rdy3 = 1'b1;

    foreach (vecs[i]) begin
      send(vecs[i].sel, vecs[i].keys, vecs[i].dec);
      chk("first subkey", outs(vecs[i].sel),
          {7'd0, 1'b0, 1'b1, 1'b0, vecs[i].idx, vecs[i].rnd, vecs[i].sk});
      wait_drain(vecs[i].sel, 0, (vecs[i].sel == 1) ? 16 : 48);
      chk_idle(vecs[i].sel);
    end

    // Consumer stall at round 3.
    send(1, {128'd0, KEY_A}, 1'b0);
    cnt = 0;
    while (!(v1 && rnd1 == 4'd3) && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (!(v1 && rnd1 == 4'd3)) fail("stall round 3 never reached");
    rdy1 = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall hold", outs(1), {7'd0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd3, ks_a[3]});
    end
    rdy1 = 1'b1;
    wait_drain(1, 0, 0);
    chk_idle(1);

    // Reset abandons a triple-DES schedule at round 7.
    send(3, {KEY_A, KEY_A, KEY_A}, 1'b0);
    cnt = 0;
    while (!(v3 && rnd3 == 4'd7) && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (!(v3 && rnd3 == 4'd7)) fail("reset round 7 never reached");
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid reset outputs", outs(3), {7'd0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 48'd0});
    q3.delete();
    send(3, {KEY_A, KEY_A, KEY_A}, 1'b0);
    chk("restart first subkey", outs(3), {7'd0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, ks_a[0]});
    wait_drain(3, 0, 48);
    chk_idle(3);

    // Key offered throughout GEN must wait for the cycle after o_last.
    @(posedge clk); #1;
    key1 = KEY_A; dec1 = 1'b0; kv1 = 1'b1;
    push_bundle(1, {128'd0, KEY_A}, 1'b0);
    @(posedge clk); #1;
    key1 = KEY_Z;
    push_bundle(1, {128'd0, KEY_Z}, 1'b0);
    wait_drain(1, 16, 16);
    chk_idle(1);
    @(posedge clk); #1;
    kv1 = 1'b0;
    chk("second bundle first", outs(1), {7'd0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 48'd0});
`ifdef DES_KEY_PARITY_CHECK_EN
    chk("parity zero key", {63'd0, perr1}, 64'd1);
`endif
    wait_drain(1, 0, 16);
    chk_idle(1);

`ifdef DES_KEY_PARITY_CHECK_EN
    send(1, {128'd0, KEY_A}, 1'b0);
    chk("parity good key", {63'd0, perr1}, 64'd0);
    wait_drain(1, 0, 16);
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
